// File: rtl/pw_store_pkg.sv
// pw_store_pkg
// Shared definitions for the password history store: replay FSM states
// and the default word width / history depth used by the store and its RAM.
package pw_store_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        REPLAY = 1'b1
    } state_t;

endpackage

// File: rtl/pw_hist_ram.sv
// pw_hist_ram
// DEPTH x DATA_W register array holding the captured history.
// The write port is clocked and cleared by the asynchronous reset.
// The read port is combinational, so a replay beat is visible in the same
// cycle its pointer is.
//
// Ports:
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset, clears every entry
//   wr_en    - write enable
//   wr_addr  - write slot
//   wr_data  - word to store
//   rd_addr  - read slot
//   rd_data  - contents of rd_addr, asynchronous
module pw_hist_ram
    import pw_store_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pw_history_store.sv
// pw_history_store
// Keeps a rolling history of the last DEPTH words seen on channel
// CAPTURE_CH and replays a requested window of it, oldest word first, over
// a valid/ready stream with a last marker.
//
// Ports:
//   clk, reset_n          - clock and asynchronous active-low reset
//   in_valid/in_channel/in_data - capture input, no backpressure
//   req_valid/req_ready   - replay request handshake (ready while idle)
//   req_offset            - newest words to skip before the window ends
//   req_len               - window length, 1..DEPTH
//   req_err               - one-cycle pulse for a rejected request
//   store_valid/store_ready/store_data/store_last - replay stream
//   overrun               - sticky, a pending window word was overwritten
//   fill_count            - valid history entries, saturates at DEPTH
module pw_history_store
    import pw_store_pkg::*;
#(
    parameter int               DATA_W     = DEF_DATA_W,
    parameter int               DEPTH      = DEF_DEPTH,
    parameter int               CH_W       = 1,
    parameter logic [CH_W-1:0]  CAPTURE_CH = '0,
    localparam int              AW         = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_channel,
    input  logic [DATA_W-1:0] in_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [AW-1:0]     req_offset,
    input  logic [AW:0]       req_len,
    output logic              req_err,
    output logic              store_valid,
    input  logic              store_ready,
    output logic [DATA_W-1:0] store_data,
    output logic              store_last,
    output logic              overrun,
    output logic [AW:0]       fill_count
);

    localparam logic [AW:0]   FILL_MAX = (AW+1)'(DEPTH);
    localparam logic [AW+1:0] DEPTH_X  = (AW+2)'(DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     wp;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       remaining;
    logic [AW:0]       margin;
    logic [AW+1:0]     window_end;
    logic [AW+1:0]     margin_init;
    logic              capture;
    logic              window_bad;
    logic              accept_req;
    logic              reject_req;
    logic              handshake;
    logic              last_beat;
    logic [DATA_W-1:0] rd_data;

    assign capture = in_valid && (in_channel == CAPTURE_CH);

    // Window checks use the fill level before this cycle's capture; the
    // extra bit keeps offset+len from wrapping.
    assign window_end = {2'b00, req_offset} + {1'b0, req_len};
    assign window_bad = (req_len == '0) || (window_end > {1'b0, fill_count});
    assign accept_req = req_valid && req_ready && !window_bad;
    assign reject_req = req_valid && req_ready && window_bad;
    assign handshake  = store_valid && store_ready;
    assign last_beat  = handshake && (remaining == (AW+1)'(1));

    // Free slots between the write pointer and the oldest pending word.
    // A capture in the accept cycle already eats one; negative means the
    // oldest word is being overwritten right now, so clamp to zero.
    assign margin_init = DEPTH_X - window_end - {{(AW+1){1'b0}}, capture};

    pw_hist_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (capture),
        .wr_addr (wp),
        .wr_data (in_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_req) state_nxt = REPLAY;
            REPLAY:  if (last_beat)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state == IDLE);
        store_valid = (state == REPLAY);
        store_last  = (state == REPLAY) && (remaining == (AW+1)'(1));
        store_data  = (state == REPLAY) ? rd_data : '0;
    end

    // Capture runs independently of the replay FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp         <= '0;
            fill_count <= '0;
        end else if (capture) begin
            wp <= wp + AW'(1);
            if (fill_count != FILL_MAX) begin
                fill_count <= fill_count + (AW+1)'(1);
            end
        end
    end

    // Replay pointer, beat count and overwrite tracking. A capture and a
    // handshake in the same cycle cancel: the beat leaves as a slot fills.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr    <= '0;
            remaining <= '0;
            margin    <= '0;
            overrun   <= 1'b0;
            req_err   <= 1'b0;
        end else begin
            req_err <= reject_req;
            if (accept_req) begin
                rd_ptr    <= wp - req_offset - req_len[AW-1:0];
                remaining <= req_len;
                margin    <= margin_init[AW+1] ? '0 : margin_init[AW:0];
                overrun   <= 1'b0;
            end else if (state == REPLAY) begin
                if (handshake) begin
                    rd_ptr    <= rd_ptr + AW'(1);
                    remaining <= remaining - (AW+1)'(1);
                end
                if (handshake && !capture) begin
                    margin <= margin + (AW+1)'(1);
                end else if (capture && !handshake) begin
                    if (margin == '0) begin
                        overrun <= 1'b1;
                    end else begin
                        margin <= margin - (AW+1)'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pw_history_store.sv
// tb_pw_history_store
// Self-checking bench for pw_history_store (DEPTH=8, DATA_W=16, CH_W=1).
// Table vectors describe requests with their expected outcome; accepted
// windows push their beats onto a scoreboard queue that is popped as the
// DUT hands beats over. Overrun and reset-mid-replay are hand sequences.
module tb_pw_history_store;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int CH_W   = 1;
    localparam int AW     = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic [CH_W-1:0]   in_channel;
    logic [DATA_W-1:0] in_data;
    logic              req_valid;
    logic              req_ready;
    logic [AW-1:0]     req_offset;
    logic [AW:0]       req_len;
    logic              req_err;
    logic              store_valid;
    logic              store_ready;
    logic [DATA_W-1:0] store_data;
    logic              store_last;
    logic              overrun;
    logic [AW:0]       fill_count;

    typedef struct {
        logic [AW-1:0]     offset;
        logic [AW:0]       len;
        bit                exp_err;
        logic [DATA_W-1:0] exp_first;
        int                stall_at;
        int                stall_cycles;
    } req_vec_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t    exp_q[$];
    req_vec_t vecs[10];
    int       tests = 0;
    int       fails = 0;

    pw_history_store #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .CH_W       (CH_W),
        .CAPTURE_CH (1'b0)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_channel  (in_channel),
        .in_data     (in_data),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_offset  (req_offset),
        .req_len     (req_len),
        .req_err     (req_err),
        .store_valid (store_valid),
        .store_ready (store_ready),
        .store_data  (store_data),
        .store_last  (store_last),
        .overrun     (overrun),
        .fill_count  (fill_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run reached %0t without finishing", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushBeat(input logic [DATA_W-1:0] d, input logic last);
        beat_t b;
        b.data = d;
        b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic captureWord(input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] d);
        in_valid   = 1'b1;
        in_channel = ch;
        in_data    = d;
        @(posedge clk); #1;
        in_valid   = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " req_ready"},   32'(req_ready),   32'd1);
        checkOutput({tag, " req_err"},     32'(req_err),     32'd0);
        checkOutput({tag, " store_valid"}, 32'(store_valid), 32'd0);
        checkOutput({tag, " store_last"},  32'(store_last),  32'd0);
        checkOutput({tag, " store_data"},  32'(store_data),  32'd0);
        checkOutput({tag, " overrun"},     32'(overrun),     32'd0);
        checkOutput({tag, " fill_count"},  32'(fill_count),  32'd0);
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after the
    // accept edge (accepted) or once the error pulse has been checked.
    task automatic sendReq(input logic [AW-1:0] off, input logic [AW:0] len,
                           input bit exp_err, input string tag);
        req_valid  = 1'b1;
        req_offset = off;
        req_len    = len;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        if (exp_err) begin
            @(negedge clk);
            checkOutput({tag, " req_err"},   32'(req_err),     32'd1);
            checkOutput({tag, " no beat"},   32'(store_valid), 32'd0);
            checkOutput({tag, " req_ready"}, 32'(req_ready),   32'd1);
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput({tag, " req_err pulse end"}, 32'(req_err), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    // Pops the scoreboard as beats are handed over. While stalled, the held
    // beat must still equal the queue head, which checks it stays stable.
    task automatic drain(input int stall_at, input int stall_cycles, input string tag);
        int cyc     = 0;
        int beat    = 0;
        int stalled = 0;
        while (exp_q.size() != 0 && cyc < 64) begin
            store_ready = !((beat == stall_at) && (stalled < stall_cycles));
            @(negedge clk);
            if (cyc == 0) checkOutput({tag, " req_err low"}, 32'(req_err), 32'd0);
            checkOutput($sformatf("%s beat%0d valid", tag, beat), 32'(store_valid), 32'd1);
            checkOutput($sformatf("%s beat%0d data", tag, beat), 32'(store_data),
                        32'(exp_q[0].data));
            checkOutput($sformatf("%s beat%0d last", tag, beat), 32'(store_last),
                        32'(exp_q[0].last));
            if (store_ready) begin
                void'(exp_q.pop_front());
                beat++;
            end else begin
                stalled++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        store_ready = 1'b1;
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s timeout: %0d beats outstanding, required 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic applyStimulus(input req_vec_t v, input string tag);
        if (!v.exp_err) begin
            for (int k = 0; k < int'(v.len); k++) begin
                pushBeat(v.exp_first + DATA_W'(k), (k == int'(v.len) - 1));
            end
        end
        sendReq(v.offset, v.len, v.exp_err, tag);
        if (!v.exp_err) begin
            drain(v.stall_at, v.stall_cycles, tag);
            @(negedge clk);
            checkOutput({tag, " req_ready after window"}, 32'(req_ready),   32'd1);
            checkOutput({tag, " valid after window"},     32'(store_valid), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        // History 0x0001..0x0005
        vecs[0] = '{3'd0, 4'd3, 1'b0, 16'h0003, -1, 0};
        vecs[1] = '{3'd4, 4'd1, 1'b0, 16'h0001, -1, 0};
        vecs[2] = '{3'd3, 4'd3, 1'b1, 16'h0000, -1, 0};
        vecs[3] = '{3'd0, 4'd0, 1'b1, 16'h0000, -1, 0};
        vecs[4] = '{3'd0, 4'd5, 1'b0, 16'h0001,  2, 1};
        vecs[5] = '{3'd1, 4'd5, 1'b1, 16'h0000, -1, 0};
        // History 0x0003..0x000A after wrap
        vecs[6] = '{3'd0, 4'd8, 1'b0, 16'h0003,  3, 2};
        vecs[7] = '{3'd2, 4'd4, 1'b0, 16'h0005, -1, 0};
        vecs[8] = '{3'd7, 4'd1, 1'b0, 16'h0003, -1, 0};
        vecs[9] = '{3'd7, 4'd2, 1'b1, 16'h0000, -1, 0};

        reset_n     = 1'b0;
        in_valid    = 1'b0;
        in_channel  = '0;
        in_data     = '0;
        req_valid   = 1'b0;
        req_offset  = '0;
        req_len     = '0;
        store_ready = 1'b1;
        @(posedge clk); #1;
        checkResetValues("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int w = 1; w <= 5; w++) begin
            captureWord(1'b0, DATA_W'(w));
            if (w == 2 || w == 4) captureWord(1'b1, 16'hBEEF);
        end
        @(negedge clk);
        checkOutput("fill after 5", 32'(fill_count), 32'd5);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        for (int w = 6; w <= 10; w++) captureWord(1'b0, DATA_W'(w));
        @(negedge clk);
        checkOutput("fill saturated", 32'(fill_count), 32'd8);
        @(posedge clk); #1;

        for (int i = 6; i < 10; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Overrun: full window, stalled, capture lands on the oldest slot.
        store_ready = 1'b0;
        sendReq(3'd0, 4'd8, 1'b0, "overrun");
        captureWord(1'b0, 16'h00FF);
        @(negedge clk);
        checkOutput("overrun set",        32'(overrun),     32'd1);
        checkOutput("overrun first data", 32'(store_data),  32'h00FF);
        checkOutput("overrun valid",      32'(store_valid), 32'd1);
        @(posedge clk); #1;
        pushBeat(16'h00FF, 1'b0);
        for (int w = 4; w <= 10; w++) pushBeat(DATA_W'(w), (w == 10));
        drain(-1, 0, "overrun");
        @(negedge clk);
        checkOutput("overrun sticky", 32'(overrun), 32'd1);
        @(posedge clk); #1;

        // Next accepted request clears overrun; newest word is now 0x00FF.
        store_ready = 1'b0;
        pushBeat(16'h00FF, 1'b1);
        sendReq(3'd0, 4'd1, 1'b0, "ovr clear");
        @(negedge clk);
        checkOutput("overrun cleared",  32'(overrun),    32'd0);
        checkOutput("ovr clear last",   32'(store_last), 32'd1);
        @(posedge clk); #1;
        drain(-1, 0, "ovr clear");

        // Reset in the middle of a window after two beats.
        pushBeat(16'h0004, 1'b0);
        pushBeat(16'h0005, 1'b0);
        sendReq(3'd0, 4'd8, 1'b0, "mid reset");
        drain(-1, 0, "mid reset");
        reset_n = 1'b0;
        #1;
        checkResetValues("mid reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("fill after reset", 32'(fill_count), 32'd0);
        @(posedge clk); #1;
        sendReq(3'd0, 4'd1, 1'b1, "post reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pw_history_store.md
# pw_history_store

Parametrised capture-and-replay store for the password datapath. Keeps a rolling history of the last DEPTH accepted words from one selected input channel. On a request, it replays a caller-chosen window of that history, oldest word first, over a valid/ready stream with a last marker. It sits between the channelised data source and the hash front end, and reports window errors and in-flight overwrites.

## Interface
Parameters:
- DATA_W, 16, data word width
- DEPTH, 8, history entries; power of two, at least 2; AW = $clog2(DEPTH)
- CH_W, 1, input channel field width
- CAPTURE_CH, 0, channel value that is captured; all other channels are ignored

Ports:
- clk  in  1  single clock; everything is on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input word present; there is no backpressure on the input
- in_channel  in  CH_W  input channel tag
- in_data  in  DATA_W  input word
- req_valid  in  1  replay request
- req_ready  out  1  high while IDLE
- req_offset  in  AW  number of newest words to skip (0 = window ends at the newest word)
- req_len  in  AW+1  window length, legal range 1..DEPTH
- req_err  out  1  one-cycle pulse when a request is rejected
- store_valid  out  1  replay beat valid
- store_ready  in  1  downstream accepts the beat
- store_data  out  DATA_W  replay word
- store_last  out  1  final beat of the window
- overrun  out  1  sticky; a pending window word was overwritten
- fill_count  out  AW+1  valid history entries, saturates at DEPTH

## Operation
- **Capture:** when in_valid && in_channel==CAPTURE_CH, write in_data to mem[wp], then wp <= wp+1 (mod DEPTH) and fill_count <= min(fill_count+1, DEPTH). Capture happens in every state.
- **FSM IDLE:** req_ready=1. A request is accepted when req_valid && req_ready.
  - Reject if req_len==0 or req_offset+req_len > fill_count. Compute the sum in AW+2 bits and use the pre-capture fill_count of the same cycle. On reject, pulse req_err and stay in IDLE.
  - Otherwise: rd_ptr <= wp - req_offset - req_len (mod DEPTH, pre-capture wp); remaining <= req_len; margin <= DEPTH - req_offset - req_len - (capture this cycle); clear overrun; go to REPLAY.
- **FSM REPLAY:** req_ready=0 and store_valid=1. store_data = mem[rd_ptr], read asynchronously from the register array. store_last = (remaining==1).
  - Handshake (store_valid && store_ready): rd_ptr++ and remaining--. On the last beat, return to IDLE.
- **Margin tracking:** margin +1 per handshake, -1 per capture. A capture with margin==0 and no handshake in the same cycle sets overrun. That word is lost, and the replay continues with whatever the slot holds when it is read. Margin saturates at 0.
- **Capture and handshake in the same cycle:** the read sees the old slot contents; no overrun, margin unchanged.

## Timing
- **Reset values:** req_ready=1, req_err=0, store_valid=0, store_last=0, store_data=0 (mem cleared), overrun=0, fill_count=0. FSM=IDLE, wp=0.
- **Request latency:** accept at cycle T gives the first beat at T+1. A reject at T gives the req_err pulse at T+1.
- **Backpressure:** store_data and store_last stay stable while store_valid && !store_ready.
- **Back-to-back requests:** req_ready rises the cycle after the last handshake, so there is one idle cycle between windows.
- **Reset mid-replay:** immediate return to the reset values; no partial window completes.

## Structure
- Package pw_store_pkg holds the state typedef (IDLE, REPLAY) and the default DATA_W/DEPTH constants.
- Sub-module pw_hist_ram holds the DEPTH x DATA_W register array: async-reset write port and asynchronous read port. The top level owns the pointers, the FSM and the margin logic.

## Test plan
- **Basic window:** DEPTH=8; capture 0x0001..0x0005 on ch0; request offset 0, len 3 -> beats 0x0003, 0x0004, 0x0005 with store_last on the third; first beat one cycle after accept.
- **Offset read:** same history; request offset 4, len 1 -> single beat 0x0001 with last=1. Interleaved ch1 words (e.g. 0xBEEF) never appear and never raise fill_count.
- **Reject:** fill_count=5; request offset 3, len 3 -> req_err pulse, no store_valid, req_ready stays 1. len=0 is rejected the same way.
- **Backpressure and wrap-around:** capture 0x0001..0x000A (wp wrapped); request offset 0, len 8 with store_ready low for 2 cycles mid-window -> 0x0003..0x000A in order, data held stable during the stall.
- **Overrun:** history full; request offset 0, len 8; hold store_ready low and capture 0x00FF -> overrun=1 and first beat reads 0x00FF. Overrun clears on the next accepted request.
- **Reset mid-replay:** assert reset_n low after 2 beats -> all outputs take their reset values at once; after release, fill_count=0 and any request is rejected.
